// File: rtl/seg7_pkg.sv
// ============================================================================
//  Module   : seg7_pkg
//  Purpose  : Shared constants, FSM state type and hex-to-segment decoder
//  Revision : 1.0
// ============================================================================
`default_nettype none

package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SCAN  = 1'b1
  } state_t;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_prescaler.sv
// ============================================================================
//  Module   : seg7_prescaler
//  Purpose  : Free-running digit-tick prescaler with post-tick anode guard
//  Revision : 1.0
// ============================================================================
`default_nettype none

module seg7_prescaler #(
  parameter int DIV_W = 16,
  parameter int GUARD = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick,
  output logic guard_blank
);

  localparam logic [DIV_W-1:0] GUARD_LD = DIV_W'(GUARD);
  localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] guard_q, guard_d;

  always_comb begin
    cnt_d   = cnt_q + ONE;
    tick    = &cnt_q;
    guard_d = guard_q;
    if (tick) begin
      guard_d = GUARD_LD;
    end else if (guard_q != '0) begin
      guard_d = guard_q - ONE;
    end
    // Looks one cycle ahead so the registered anodes go dark on the cycle right after the tick
    guard_blank = tick || (guard_q > ONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      guard_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      guard_q <= guard_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/seg7_scan_driver.sv
// ============================================================================
//  Module   : seg7_scan_driver
//  Purpose  : Tear-free, ghost-free 4-digit hex scanner with valid/ready input
//  Revision : 1.0
// ============================================================================
`default_nettype none

module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int GUARD = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_strb
);

  logic tick;
  logic guard_blank;

  seg7_prescaler #(
    .DIV_W (DIV_W),
    .GUARD (GUARD)
  ) u_prescaler (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .guard_blank (guard_blank)
  );

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] disp_q, disp_d;
  logic [15:0] pend_q, pend_d;
  logic        pend_full_q, pend_full_d;
  logic        data_ready_q, data_ready_d;
  logic        frame_strb_q, frame_strb_d;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;

  logic        xfer;
  logic [3:0]  shamt;
  logic [3:0]  nib;
  logic [15:0] upper;
  logic        lz_blank;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    disp_d       = disp_q;
    pend_d       = pend_q;
    pend_full_d  = pend_full_q;
    frame_strb_d = 1'b0;

    xfer = data_valid && data_ready_q;
    if (xfer) begin
      pend_d      = data_in;
      pend_full_d = 1'b1;
    end

    // A commit never coincides with a transfer: ready is low whenever pend_full is set
    case (state_q)
      ST_BLANK: begin
        if (tick && pend_full_q) begin
          disp_d      = pend_q;
          pend_full_d = 1'b0;
          idx_d       = 2'd0;
          state_d     = ST_SCAN;
        end
      end
      default: begin
        if (tick) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            frame_strb_d = 1'b1;
            if (pend_full_q) begin
              disp_d      = pend_q;
              pend_full_d = 1'b0;
            end
          end
        end
      end
    endcase

    data_ready_d = !pend_full_d;

    shamt    = {idx_q, 2'b00};
    nib      = disp_q[shamt +: 4];
    upper    = disp_q >> shamt;
    lz_blank = blank_lz && (idx_q != 2'd0) && (upper == 16'h0000);

    if (state_q == ST_BLANK) begin
      seg_d = SEG_BLANK;
      an_d  = AN_OFF;
    end else begin
      seg_d = hex2seg(nib);
      an_d  = (guard_blank || lz_blank) ? AN_OFF : ~(4'b0001 << idx_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_BLANK;
      idx_q        <= 2'd0;
      disp_q       <= 16'h0000;
      pend_q       <= 16'h0000;
      pend_full_q  <= 1'b0;
      data_ready_q <= 1'b1;
      frame_strb_q <= 1'b0;
      seg_q        <= SEG_BLANK;
      an_q         <= AN_OFF;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_full_q  <= pend_full_d;
      data_ready_q <= data_ready_d;
      frame_strb_q <= frame_strb_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign data_ready = data_ready_q;
  assign frame_strb = frame_strb_q;
  assign seg        = seg_q;
  assign an         = an_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
// ============================================================================
//  Module   : tb_seg7_scan_driver
//  Purpose  : Self-checking bench for seg7_scan_driver (DIV_W=4, GUARD=2)
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seg7_scan_driver;

  localparam int DIV_W  = 4;
  localparam int GUARD  = 2;
  localparam int PERIOD = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] data_in = 16'h0000;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_strb;

  int checks = 0;
  int errors = 0;

  seg7_scan_driver #(
    .DIV_W (DIV_W),
    .GUARD (GUARD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .an         (an),
    .frame_strb (frame_strb)
  );

  always #5 clk = ~clk;

  // Reference model: values held during clock period n (n counted from reset release)
  int          n;
  bit          m_scan, p_scan;
  int          m_idx, p_idx;
  logic [15:0] m_disp, p_disp, m_pend;
  bit          m_full;
  bit          p_lz;
  bit          p_wrap;
  bit          m_xfer;

  function automatic logic [6:0] ref_seg(input int v);
    case (v)
      0:  return 7'b1000000;
      1:  return 7'b1111001;
      2:  return 7'b0100100;
      3:  return 7'b0110000;
      4:  return 7'b0011001;
      5:  return 7'b0010010;
      6:  return 7'b0000010;
      7:  return 7'b1111000;
      8:  return 7'b0000000;
      9:  return 7'b0010000;
      10: return 7'b0001000;
      11: return 7'b0000011;
      12: return 7'b1000110;
      13: return 7'b0100001;
      14: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, n);
    end
  endtask

  task automatic model_reset();
    n = 0; m_scan = 0; p_scan = 0; m_idx = 0; p_idx = 0;
    m_disp = '0; p_disp = '0; m_pend = '0; m_full = 0;
    p_lz = 0; p_wrap = 0; m_xfer = 0;
  endtask

  task automatic model_edge();
    bit tick;
    tick   = (n % PERIOD) == PERIOD - 1;
    p_scan = m_scan; p_idx = m_idx; p_disp = m_disp; p_lz = blank_lz;
    p_wrap = m_scan && tick && (m_idx == 3);
    m_xfer = data_valid && !m_full;
    if (m_scan) begin
      if (tick) begin
        if (m_idx == 3 && m_full) begin
          m_disp = m_pend; m_full = 0;
        end
        m_idx = (m_idx + 1) % 4;
      end
    end else if (tick && m_full) begin
      m_disp = m_pend; m_full = 0; m_idx = 0; m_scan = 1;
    end
    if (m_xfer) begin
      m_pend = data_in; m_full = 1;
    end
    n++;
  endtask

  task automatic check_outputs();
    logic [6:0] es;
    logic [3:0] ea;
    int         digit;
    bit         lz;
    digit = int'((p_disp >> (4 * p_idx)) & 16'hF);
    lz    = p_lz && (p_idx != 0) && ((p_disp >> (4 * p_idx)) == 16'h0);
    if (!p_scan) begin
      es = 7'h7F; ea = 4'hF;
    end else begin
      es = ref_seg(digit);
      if ((n % PERIOD) < GUARD || lz) ea = 4'hF;
      else                            ea = ~(4'b0001 << p_idx);
    end
    chk("seg", 32'(seg), 32'(es));
    chk("an", 32'(an), 32'(ea));
    chk("data_ready", 32'(data_ready), 32'(!m_full));
    chk("frame_strb", 32'(frame_strb), 32'(p_wrap));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) cycle();
  endtask

  task automatic send(input logic [15:0] w);
    bit acc;
    acc = 0;
    data_in = w; data_valid = 1'b1;
    for (int k = 0; k < 200 && !acc; k++) begin
      cycle();
      acc = m_xfer;
    end
    data_valid = 1'b0;
    chk("send_accept", 32'(acc), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_an"}, 32'(an), 32'hF);
    chk({tag, "_seg"}, 32'(seg), 32'h7F);
    chk({tag, "_ready"}, 32'(data_ready), 32'd1);
    chk({tag, "_strb"}, 32'(frame_strb), 32'd0);
  endtask

  initial begin
    bit done;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst_hold");
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    check_reset_values("rst_rel");

    // Idle with no data
    run(110);

    // Single word, full frame
    send(16'h12AF);
    run(80);

    // Leading-zero suppression
    blank_lz = 1'b1;
    send(16'h0000);
    run(80);
    send(16'h0050);
    run(80);
    blank_lz = 1'b0;

    // Mid-frame update must wait for the frame boundary
    send(16'h1234);
    done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      cycle();
      done = !m_full && (m_disp == 16'h1234) && (m_idx == 1);
    end
    chk("wait_1234_mid", 32'(done), 32'd1);
    send(16'hBEEF);
    run(100);

    // Valid held high with changing data while not ready
    data_valid = 1'b1;
    for (int k = 0; k < 120; k++) begin
      data_in = 16'($urandom);
      cycle();
    end
    data_valid = 1'b0;
    run(70);

    // Randomised traffic
    for (int k = 0; k < 600; k++) begin
      data_valid = ($urandom_range(0, 3) == 0);
      data_in    = 16'($urandom);
      if (k % 50 == 0) blank_lz = 1'($urandom_range(0, 1));
      cycle();
    end
    data_valid = 1'b0;
    blank_lz   = 1'b0;
    run(40);

    // Asynchronous reset mid-digit with a pending word
    send(16'hC0DE);
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("async_rst");
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst_held2");
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    run(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
